// File: rtl/fetch_if.sv
// fetch_if: control, instruction-memory and IF/ID signals of the fetch stage
interface fetch_if;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        redirect_misaligned;
    logic [31:0] fetch_count;
    modport master (
        output stall, redirect_en, redirect_target, imem_data,
        input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, redirect_misaligned, fetch_count
    );
    modport slave (
        input  stall, redirect_en, redirect_target, imem_data,
        output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, redirect_misaligned, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, PC+4 and IF/ID pipeline register with stall/redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input logic clk,
    input logic rst,
    fetch_if.slave bus
);
    logic [31:0] pc, pc_plus4, instr, pc4_q, cnt;
    logic        valid, mis;
    assign pc_plus4 = pc + 32'd4;
    // redirect outranks stall so a resolved branch is never lost behind a hazard
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            instr <= NOP_INSTR;
            pc4_q <= 32'd0;
            valid <= 1'b0;
            mis   <= 1'b0;
            cnt   <= 32'd0;
        end else if (bus.redirect_en) begin
            pc    <= {bus.redirect_target[31:2], 2'b00};
            instr <= NOP_INSTR;
            valid <= 1'b0;
            mis   <= |bus.redirect_target[1:0];
        end else if (bus.stall) begin
            mis   <= 1'b0;
        end else begin
            pc    <= pc_plus4;
            instr <= bus.imem_data;
            pc4_q <= pc_plus4;
            valid <= 1'b1;
            mis   <= 1'b0;
            cnt   <= cnt + 32'd1;
        end
    end
    assign bus.imem_addr           = pc;
    assign bus.ifid_instr          = instr;
    assign bus.ifid_pc_plus4       = pc4_q;
    assign bus.ifid_valid          = valid;
    assign bus.redirect_misaligned = mis;
    assign bus.fetch_count         = cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors with a scoreboard queue checked by a monitor
module tb_fetch_stage;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    exp_t q[$];

    fetch_if bus();
    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    assign bus.imem_data = bus.imem_addr | 32'hA000_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("imem_addr", bus.imem_addr, e.addr);
                chk("ifid_instr", bus.ifid_instr, e.instr);
                chk("ifid_pc_plus4", bus.ifid_pc_plus4, e.pc4);
                chk("ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, e.valid});
                chk("redirect_misaligned", {31'd0, bus.redirect_misaligned}, {31'd0, e.mis});
                chk("fetch_count", bus.fetch_count, e.cnt);
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic re, input logic [31:0] tgt,
                        input logic frc, input logic [31:0] ea, input logic [31:0] ei,
                        input logic [31:0] ep, input logic ev, input logic em, input logic [31:0] ec);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.stall = s;
        bus.redirect_en = re;
        bus.redirect_target = tgt;
        if (frc) begin
            force dut.cnt = 32'hFFFF_FFFF;
            #1;
            release dut.cnt;
        end
        @(posedge clk);
        e = '{addr: ea, instr: ei, pc4: ep, valid: ev, mis: em, cnt: ec};
        q.push_back(e);
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_target = 32'h0;
        // reset and sequential fetch
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h4, 32'hA000_0000, 32'h4, 1, 0, 1);
        step(0, 0, 0, 0, 0, 32'h8, 32'hA000_0004, 32'h8, 1, 0, 2);
        step(0, 0, 0, 0, 0, 32'hC, 32'hA000_0008, 32'hC, 1, 0, 3);
        step(0, 0, 0, 0, 0, 32'h10, 32'hA000_000C, 32'h10, 1, 0, 4);
        // stall after two fetches
        step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h4, 32'hA000_0000, 32'h4, 1, 0, 1);
        step(0, 0, 0, 0, 0, 32'h8, 32'hA000_0004, 32'h8, 1, 0, 2);
        step(0, 1, 0, 0, 0, 32'h8, 32'hA000_0004, 32'h8, 1, 0, 2);
        step(0, 1, 0, 0, 0, 32'h8, 32'hA000_0004, 32'h8, 1, 0, 2);
        step(0, 1, 0, 0, 0, 32'h8, 32'hA000_0004, 32'h8, 1, 0, 2);
        step(0, 0, 0, 0, 0, 32'hC, 32'hA000_0008, 32'hC, 1, 0, 3);
        // redirect together with stall
        step(0, 1, 1, 32'h100, 0, 32'h100, 32'h0, 32'hC, 0, 0, 3);
        step(0, 0, 0, 0, 0, 32'h104, 32'hA000_0100, 32'h104, 1, 0, 4);
        // misaligned redirect, flag lasts one cycle
        step(0, 0, 1, 32'h203, 0, 32'h200, 32'h0, 32'h104, 0, 1, 4);
        step(0, 0, 0, 0, 0, 32'h204, 32'hA000_0200, 32'h204, 1, 0, 5);
        // PC and fetch_count wrap
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h0, 32'h204, 0, 0, 5);
        step(0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 32'h4, 32'hA000_0000, 32'h4, 1, 0, 1);
        step(0, 0, 0, 0, 0, 32'h8, 32'hA000_0004, 32'h8, 1, 0, 2);
        step(0, 0, 0, 0, 0, 32'hC, 32'hA000_0008, 32'hC, 1, 0, 3);
        step(0, 0, 0, 0, 0, 32'h10, 32'hA000_000C, 32'h10, 1, 0, 4);
        step(0, 0, 0, 0, 0, 32'h14, 32'hA000_0010, 32'h14, 1, 0, 5);
        // reset beats a concurrent redirect
        step(1, 0, 1, 32'h303, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h4, 32'hA000_0000, 32'h4, 1, 0, 1);
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
